// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch/loader block.
// The state encoding, parity function and default NOP word live here.
package imem_pkg;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StLoad
  } state_e;

  // Widest word the parity helper accepts; narrower callers zero-extend.
  localparam int unsigned ParMaxW = 256;

  localparam logic [31:0] NopWordDefault = 32'h0000_0000;

  function automatic logic even_parity(input logic [ParMaxW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Depth x Width storage: one synchronous write port, one registered read port.
// Only the read register is reset; contents are zeroed by the owner's clear engine.
module imem_array #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [IdxW-1:0]  i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_re,
  input  logic [IdxW-1:0]  i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read data holds until the next read so the consumer sees a stable word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_loader.sv
// Instruction memory with registered fetch port, burst program loader and post-reset clear.
// Optional per-word even parity with fetch_err / inj_par ports when IMEM_PARITY_EN is defined.
module imem_fetch_loader
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 16,
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NopWordDefault)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
`ifdef IMEM_PARITY_EN
  ,
  output logic              fetch_err,
  input  logic              inj_par
`endif
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(DEPTH - 1);
  localparam logic [ADDR_W:0]   AddrLim = (ADDR_W + 1)'(DEPTH);

  state_e          r_state, w_state_next;
  logic [IdxW-1:0] r_ctr, w_ctr_next;
  logic [IdxW-1:0] r_ptr, w_ptr_next;
  logic            r_fetch_valid;
  logic            r_oob;
  logic            r_load_done;

  logic            w_we;
  logic [IdxW-1:0] w_waddr;
  logic [MemW-1:0] w_wdata;
  logic [MemW-1:0] w_load_word;
  logic [MemW-1:0] w_rdata;
  logic            w_fetch_acc;
  logic            w_done_next;
  logic            w_in_range;
  logic [IdxW-1:0] w_base_idx;

  // One extra address bit so DEPTH == 2^ADDR_W still compares correctly.
  assign w_in_range = {1'b0, fetch_addr} < AddrLim;
  assign w_base_idx = IdxW'({1'b0, load_base} % AddrLim);

`ifdef IMEM_PARITY_EN
  assign w_load_word = {even_parity(ParMaxW'(load_data)) ^ inj_par, load_data};
  assign fetch_err   = !r_oob && (w_rdata[DATA_W] != even_parity(ParMaxW'(w_rdata[DATA_W-1:0])));
`else
  assign w_load_word = load_data;
`endif

  always_comb begin
    w_state_next = r_state;
    w_ctr_next   = r_ctr;
    w_ptr_next   = r_ptr;
    w_we         = 1'b0;
    w_waddr      = r_ptr;
    w_wdata      = '0;
    w_fetch_acc  = 1'b0;
    w_done_next  = 1'b0;
    unique case (r_state)
      StClear: begin
        w_we    = 1'b1;
        w_waddr = r_ctr;
        if (r_ctr == LastIdx) begin
          w_state_next = StIdle;
          w_ctr_next   = '0;
        end else begin
          w_ctr_next = r_ctr + IdxW'(1);
        end
      end
      StIdle: begin
        // A same-cycle fetch reads before the first load write lands.
        w_fetch_acc = fetch_req;
        if (load_start) begin
          w_state_next = StLoad;
          w_ptr_next   = w_base_idx;
        end
      end
      StLoad: begin
        if (load_valid) begin
          w_we       = 1'b1;
          w_wdata    = w_load_word;
          w_ptr_next = (r_ptr == LastIdx) ? '0 : r_ptr + IdxW'(1);
          if (load_last) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = StClear;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= StClear;
      r_ctr         <= '0;
      r_ptr         <= '0;
      r_fetch_valid <= 1'b0;
      r_oob         <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ctr         <= w_ctr_next;
      r_ptr         <= w_ptr_next;
      r_fetch_valid <= w_fetch_acc;
      r_load_done   <= w_done_next;
      if (w_fetch_acc) begin
        r_oob <= !w_in_range;
      end
    end
  end

  imem_array #(
    .Width (MemW),
    .Depth (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch_acc && w_in_range),
    .i_raddr (fetch_addr[IdxW-1:0]),
    .o_rdata (w_rdata)
  );

  assign fetch_ready = (r_state == StIdle);
  assign load_ready  = (r_state == StLoad);
  assign busy        = (r_state != StIdle);
  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_oob ? NOP_WORD : w_rdata[DATA_W-1:0];
  assign load_done   = r_load_done;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Self-checking bench for imem_fetch_loader: vector table, hand sequences and
// randomized bursts/fetches checked against an array-based memory model.
module tb_imem_fetch_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK;
  logic        RESET;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        load_start;
  logic [9:0]  load_base;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        busy;
`ifdef IMEM_PARITY_EN
  logic        fetch_err;
  logic        inj_par;
`endif

  imem_fetch_loader #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy)
`ifdef IMEM_PARITY_EN
    ,
    .fetch_err   (fetch_err),
    .inj_par     (inj_par)
`endif
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] model [DEPTH];
  logic [31:0] burst_q [$];
  vec_t        vecs [10];
  int          n_pass  = 0;
  int          n_total = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_read(input logic [9:0] a);
    if (int'(a) < DEPTH) return model[a % DEPTH];
    return NOP;
  endfunction

  // Counts busy cycles after a reset edge while poking ignored requests.
  task automatic wait_clear(input string tag);
    int cycles = 0;
    bit saw_valid = 1'b0;
    bit saw_done = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      if (fetch_valid !== 1'b0) saw_valid = 1'b1;
      if (load_done !== 1'b0) saw_done = 1'b1;
      fetch_req  = (cycles < 10);
      fetch_addr = 10'd3;
      load_start = (cycles < 10);
      load_base  = 10'd7;
      cycles++;
      step();
    end
    fetch_req  = 1'b0;
    load_start = 1'b0;
    check({tag, "_clear_cycles"}, 64'(cycles), 64'(DEPTH));
    check({tag, "_no_fetch_valid"}, 64'(saw_valid), 64'(0));
    check({tag, "_no_load_done"}, 64'(saw_done), 64'(0));
    check({tag, "_fetch_ready"}, 64'(fetch_ready), 64'(1));
    check({tag, "_load_ready"}, 64'(load_ready), 64'(0));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_fetch(input logic [9:0] a, input string tag);
    logic [31:0] exp = ref_read(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    check({tag, "_valid"}, 64'(fetch_valid), 64'(1));
    check({tag, "_data"}, 64'(fetch_data), 64'(exp));
    step();
    check({tag, "_valid_drop"}, 64'(fetch_valid), 64'(0));
    check({tag, "_data_hold"}, 64'(fetch_data), 64'(exp));
  endtask

  // Writes burst_q starting at base, optionally with idle beats and ignored strobes.
  task automatic do_load(input logic [9:0] base, input bit gaps, input string tag);
    int p = int'(base) % DEPTH;
    int n = burst_q.size();
    load_start = 1'b1;
    load_base  = base;
    step();
    load_start = 1'b0;
    check({tag, "_ready"}, 64'({load_ready, fetch_ready, busy}), 64'(3'b101));
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          load_valid = 1'b0;
          load_last  = 1'($urandom_range(0, 1));
          load_start = 1'($urandom_range(0, 1));
          load_base  = 10'($urandom);
          step();
          check({tag, "_gap"}, 64'({load_done, load_ready}), 64'(2'b01));
        end
      end
      load_start = 1'b0;
      load_valid = 1'b1;
      load_last  = (i == n - 1);
      load_data  = burst_q[i];
      step();
      model[p] = burst_q[i];
      p = (p + 1) % DEPTH;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check({tag, "_done"}, 64'({load_done, fetch_ready, busy}), 64'(3'b110));
    step();
    check({tag, "_done_pulse"}, 64'(load_done), 64'(0));
  endtask

  initial begin
    vecs[0] = '{addr: 10'd14,   exp: 32'h0000_00A0};
    vecs[1] = '{addr: 10'd15,   exp: 32'h0000_00A1};
    vecs[2] = '{addr: 10'd0,    exp: 32'h0000_00A2};
    vecs[3] = '{addr: 10'd1,    exp: 32'h0000_00A3};
    vecs[4] = '{addr: 10'd5,    exp: 32'h0000_0000};
    vecs[5] = '{addr: 10'd13,   exp: 32'h0000_0000};
    vecs[6] = '{addr: 10'd20,   exp: NOP};
    vecs[7] = '{addr: 10'd16,   exp: NOP};
    vecs[8] = '{addr: 10'd1023, exp: NOP};
    vecs[9] = '{addr: 10'd2,    exp: 32'h0000_0000};

    RESET = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_base = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
`ifdef IMEM_PARITY_EN
    inj_par = 1'b0;
`endif
    step();
    step();
    check("reset_busy", 64'(busy), 64'(1));
    check("reset_ready", 64'({fetch_ready, load_ready}), 64'(0));
    check("reset_fetch", 64'({fetch_valid, fetch_data}), 64'(0));
    check("reset_done", 64'(load_done), 64'(0));
`ifdef IMEM_PARITY_EN
    check("reset_err", 64'(fetch_err), 64'(0));
`endif
    RESET = 1'b0;
    wait_clear("boot");
    do_fetch(10'd5, "boot_a5");

    burst_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_load(10'd14, 1'b0, "wrap");
    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].addr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table", i), 64'(fetch_data), 64'(vecs[i].exp));
    end

    fetch_req = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      fetch_addr = 10'(a);
      step();
      check($sformatf("b2b%0d", a), 64'({fetch_valid, fetch_data}), {31'd0, 1'b1, ref_read(10'(a))});
    end
    fetch_req = 1'b0;
    step();
    check("b2b_end", 64'(fetch_valid), 64'(0));

    // Fetch and load_start together: fetch sees pre-load data; fetch in LOAD is ignored.
    begin
      logic [31:0] old = model[4];
      fetch_req  = 1'b1;
      fetch_addr = 10'd4;
      load_start = 1'b1;
      load_base  = 10'd52;
      step();
      load_start = 1'b0;
      fetch_addr = 10'd0;
      check("same_fetch", 64'({fetch_valid, fetch_data}), {31'd0, 1'b1, old});
      check("same_state", 64'({load_ready, fetch_ready}), 64'(2'b10));
      load_valid = 1'b1;
      load_last  = 1'b1;
      load_data  = 32'h5555_AAAA;
      step();
      fetch_req  = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      model[4] = 32'h5555_AAAA;
      check("same_no_fetch_in_load", 64'(fetch_valid), 64'(0));
      check("same_done", 64'(load_done), 64'(1));
      step();
      do_fetch(10'd4, "same_a4");
    end

    for (int b = 0; b < 8; b++) begin
      int len = int'($urandom_range(1, 20));
      burst_q = {};
      for (int i = 0; i < len; i++) burst_q.push_back($urandom);
      do_load(10'($urandom), 1'b1, $sformatf("rnd%0d", b));
      for (int f = 0; f < 6; f++) begin
        logic [9:0] a = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 17));
        do_fetch(a, $sformatf("rnd%0d_f%0d", b, f));
      end
    end

    // Reset mid-burst, with a final beat presented at the reset edge.
    load_start = 1'b1;
    load_base  = 10'd3;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC0DE_0000 + 32'(i);
      step();
    end
    load_data = 32'hC0DE_00FF;
    load_last = 1'b1;
    RESET     = 1'b1;
    step();
    RESET      = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("abort_state", 64'({load_done, load_ready, busy}), 64'(3'b001));
    wait_clear("abort");
    for (int a = 0; a < DEPTH; a++) do_fetch(10'(a), $sformatf("abort_a%0d", a));

`ifdef IMEM_PARITY_EN
    inj_par = 1'b1;
    burst_q = '{32'h7};
    do_load(10'd2, 1'b0, "par_bad");
    inj_par = 1'b0;
    do_fetch(10'd2, "par_bad_f");
    check("par_err_set", 64'(fetch_err), 64'(1));
    do_load(10'd2, 1'b0, "par_good");
    do_fetch(10'd2, "par_good_f");
    check("par_err_clr", 64'(fetch_err), 64'(0));
    do_fetch(10'd40, "par_oob");
    check("par_err_oob", 64'(fetch_err), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_loader.md
Name: imem_fetch_loader

Overview:
- Parametrised successor to the team's single-port instruction memory: configurable word width and depth.
- Replaces the flat array with three mechanisms:
  - a registered fetch port with a ready/valid handshake,
  - a burst program-load port with an auto-incrementing write pointer,
  - a sequential clear engine that zeroes the array after reset.
- Sits between the fetch stage and the test/boot loader; replaces file-driven preload in synthesisable builds.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 16, number of words; any value ≥ 2, not required to be a power of two.
- ADDR_W, 10, width of fetch/load address ports; must satisfy 2^ADDR_W ≥ DEPTH.
- NOP_WORD, 0, value returned for an out-of-range fetch.

Ports:
- CLK, input, 1, clock; all state changes on rising edge.
- RESET, input, 1, synchronous, active-high reset.
- fetch_req, input, 1, fetch request; accepted when fetch_req && fetch_ready.
- fetch_addr, input, ADDR_W, word address of fetch.
- fetch_ready, output, 1, high only in IDLE.
- fetch_valid, output, 1, one-cycle pulse, exactly 1 cycle after acceptance.
- fetch_data, output, DATA_W, registered read data; holds its value until the next valid.
- load_start, input, 1, begins a burst; honoured only in IDLE.
- load_base, input, ADDR_W, first write address; sampled with load_start.
- load_valid, input, 1, load word present.
- load_data, input, DATA_W, word to write.
- load_last, input, 1, marks the final word of the burst.
- load_ready, output, 1, high only in LOAD.
- load_done, output, 1, one-cycle pulse, 1 cycle after the last write.
- busy, output, 1, high in CLEAR or LOAD.

Behaviour:
- States: CLEAR, IDLE, LOAD. RESET (sampled at edge) forces CLEAR from any state, including mid-burst, and aborts the burst with no load_done.
- Reset values of outputs:
  - fetch_valid = 0, fetch_data = 0.
  - load_done = 0, load_ready = 0, fetch_ready = 0, busy = 1.
  - Clear counter = 0.
- CLEAR:
  - Writes 0 to word[ctr] each cycle; ctr increments.
  - After writing word DEPTH-1 → IDLE. CLEAR therefore occupies exactly DEPTH cycles after RESET deasserts.
  - Requests arriving during CLEAR are ignored, not queued.
- IDLE:
  - fetch_ready = 1.
  - Accepted fetch: if fetch_addr < DEPTH, the next cycle gives fetch_data = word[fetch_addr] and fetch_valid = 1; otherwise fetch_data = NOP_WORD with fetch_valid = 1.
  - load_start → LOAD; ptr = load_base mod DEPTH.
  - If a fetch and load_start occur in the same cycle, both are accepted; the fetch returns the pre-load contents.
- LOAD:
  - load_ready = 1, fetch_ready = 0.
  - Each cycle with load_valid: word[ptr] ← load_data; ptr ← (ptr == DEPTH-1) ? 0 : ptr+1, i.e. wrap-around.
  - Idle cycles (load_valid = 0) are allowed with no write.
  - load_valid && load_last → write, then IDLE; load_done pulses in the first IDLE cycle.
  - load_last without load_valid is ignored.
  - load_start in LOAD is ignored.
- Writes are single-port; no fetch is performed during CLEAR or LOAD, so no read-during-write case exists.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- With it defined:
  - Each word stores an extra even-parity bit, computed on every write; CLEAR stores parity 0.
  - Added output fetch_err (1 bit) is registered alongside fetch_valid and is high when the stored parity mismatches the data.
  - An out-of-range fetch gives fetch_err = 0.
  - Test-only input inj_par (1 bit) inverts the stored parity of LOAD writes.
- Without it: no parity storage, and no fetch_err or inj_par ports.

Decomposition:
- Shared package imem_pkg holds:
  - the state encoding (CLEAR, IDLE, LOAD),
  - the parity function,
  - the default NOP_WORD.
- One sub-module, imem_array: DEPTH × DATA_W(+1) storage with one synchronous write port and one registered read port.
- The FSM, pointer and handshake logic live in the top level.

Test Plan:
- RESET for 1 cycle, DEPTH=16 → busy stays high for 16 cycles, fetch_ready rises in cycle 17, and fetch of addr 5 returns 0x00000000.
- Load base=14, words 0xA0, 0xA1, 0xA2, 0xA3 with last on the fourth → words land at 14, 15, 0, 1 (wrap); load_done pulses once; fetch addr 0 returns 0xA2.
- Back-to-back fetches of addrs 1, 2, 3 on consecutive cycles → three consecutive fetch_valid pulses with matching data, each 1 cycle after its request.
- Fetch addr 20 with DEPTH=16 → fetch_data = NOP_WORD and fetch_valid = 1.
- RESET asserted after 2 of 4 burst words → no load_done, full CLEAR re-runs, and all words read 0.
- With IMEM_PARITY_EN, load 0x7 with inj_par=1 and fetch it → fetch_err = 1; rewrite with inj_par=0 → fetch_err = 0.
